// File: rtl/branch_pkg.sv
// Shared definitions for the branch sequencer: condition codes, FSM states
// and default sizing.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam int unsigned DEFAULT_XLEN         = 64;
  localparam int unsigned DEFAULT_FLUSH_CYCLES = 2;
  localparam int unsigned DEFAULT_CNT_W        = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESOLVE,
    ST_REDIRECT,
    ST_FLUSH
  } br_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator; funct3 010/011 flag illegal and
// never report taken.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = DEFAULT_XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      BEQ:     taken = (op_a == op_b);
      BNE:     taken = (op_a != op_b);
      BLT:     taken = ($signed(op_a) <  $signed(op_b));
      BGE:     taken = ($signed(op_a) >= $signed(op_b));
      BLTU:    taken = (op_a <  op_b);
      BGEU:    taken = (op_a >= op_b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Resolves one conditional branch at a time, redirects fetch on taken
// branches, then holds a fixed-length flush. Keeps saturating perf counters.
module branch_sequencer
  import branch_pkg::*;
#(
  parameter int unsigned XLEN         = DEFAULT_XLEN,
  parameter int unsigned FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
  parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_funct3,
  input  logic [XLEN-1:0]  br_op_a,
  input  logic [XLEN-1:0]  br_op_b,
  input  logic [XLEN-1:0]  br_pc,
  input  logic [XLEN-1:0]  br_imm,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             stall,
  output logic             misalign_err,
  output logic             illegal_funct3,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
    $error("branch_sequencer: FLUSH_CYCLES must be at least 1");
  end

  // Counter only needs to reach FLUSH_CYCLES-1.
  localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

  br_state_e         state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   op_a_q, op_a_d;
  logic [XLEN-1:0]   op_b_q, op_b_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              flush_q, flush_d;
  logic [FCNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic              misalign_err_q, misalign_err_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  br_count_q, br_count_d;
  logic [CNT_W-1:0]  taken_count_q, taken_count_d;

  logic              cond_taken;
  logic              cond_illegal;
  logic [XLEN-1:0]   target;

  branch_cond_eval #(.XLEN(XLEN)) u_cond_eval (
    .funct3  (funct3_q),
    .op_a    (op_a_q),
    .op_b    (op_b_q),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  assign target = pc_q + imm_q;

  always_comb begin
    state_d          = state_q;
    funct3_d         = funct3_q;
    op_a_d           = op_a_q;
    op_b_d           = op_b_q;
    pc_d             = pc_q;
    imm_d            = imm_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    flush_cnt_d      = flush_cnt_q;
    misalign_err_d   = 1'b0;
    illegal_d        = 1'b0;
    br_count_d       = br_count_q;
    taken_count_d    = taken_count_q;

    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          funct3_d = br_funct3;
          op_a_d   = br_op_a;
          op_b_d   = br_op_b;
          pc_d     = br_pc;
          imm_d    = br_imm;
          state_d  = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (br_count_q != '1) br_count_d = br_count_q + CNT_W'(1);
        state_d = ST_IDLE;
        if (cond_illegal) begin
          illegal_d = 1'b1;
        end else if (cond_taken) begin
          if (target[1:0] != 2'b00) begin
            misalign_err_d = 1'b1;
          end else begin
            redirect_pc_d    = target;
            redirect_valid_d = 1'b1;
            state_d          = ST_REDIRECT;
          end
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          redirect_valid_d = 1'b0;
          if (taken_count_q != '1) taken_count_d = taken_count_q + CNT_W'(1);
          flush_d     = 1'b1;
          flush_cnt_d = FLUSH_LOAD;
          state_d     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          flush_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - FCNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      funct3_q         <= '0;
      op_a_q           <= '0;
      op_b_q           <= '0;
      pc_q             <= '0;
      imm_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      flush_cnt_q      <= '0;
      misalign_err_q   <= 1'b0;
      illegal_q        <= 1'b0;
      br_count_q       <= '0;
      taken_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      funct3_q         <= funct3_d;
      op_a_q           <= op_a_d;
      op_b_q           <= op_b_d;
      pc_q             <= pc_d;
      imm_q            <= imm_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      flush_cnt_q      <= flush_cnt_d;
      misalign_err_q   <= misalign_err_d;
      illegal_q        <= illegal_d;
      br_count_q       <= br_count_d;
      taken_count_q    <= taken_count_d;
    end
  end

  // Issue handshake is decoded straight from state.
  assign stall          = (state_q != ST_IDLE);
  assign br_ready       = ~stall;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign misalign_err   = misalign_err_q;
  assign illegal_funct3 = illegal_q;
  assign br_count       = br_count_q;
  assign taken_count    = taken_count_q;

endmodule
